// File: rtl/segre_pipe_ctrl.sv
// Pipeline hazard/stall controller for the SEGRE in-order core.
// Latency: 0 cycles. All control outputs are combinational (Mealy) from the registered FSM state and same-cycle inputs.
// Backpressure: mem_busy_i freezes IF/ID/EX. A watchdog flags mem_timeout_o after 256 consecutive busy cycles in MEM_WAIT.
//
// Ports:
//   clk_i, rsn_i                 clock, asynchronous active-low reset
//   id_*                         ID-stage instruction source operands
//   ex_*                         EX-stage instruction info (valid, load, rd)
//   tkbr_i                       EX branch/jump taken
//   mem_busy_i                   MEM stage stalled this cycle
//   finish_test_i                EX instruction ends the test
//   block_if_o/id_o/ex_o         hold the stage flops
//   inject_nops_ex_o             EX loads a bubble
//   flush_id_o                   invalidate IF/ID register
//   halted_o                     core halted (exit only by reset)
//   mem_timeout_o                sticky watchdog error
//   state_o                      RUN=0, MEM_WAIT=1, DRAIN=2, HALT=3
// Optional feature macro SEGRE_STALL_CNT_EN adds stall_cnt_o / flush_cnt_o
// saturating performance counters.

module segre_pipe_ctrl (
  input  logic        clk_i,
  input  logic        rsn_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_use_rs1_i,
  input  logic        id_use_rs2_i,
  input  logic        ex_valid_i,
  input  logic        ex_memop_rd_i,
  input  logic [4:0]  ex_rf_waddr_i,
  input  logic        tkbr_i,
  input  logic        mem_busy_i,
  input  logic        finish_test_i,
  output logic        block_if_o,
  output logic        block_id_o,
  output logic        block_ex_o,
  output logic        inject_nops_ex_o,
  output logic        flush_id_o,
  output logic        halted_o,
  output logic        mem_timeout_o,
`ifdef SEGRE_STALL_CNT_EN
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
`endif
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALT     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  wdog_q, wdog_d;
  logic [1:0]  drain_q, drain_d;
  logic        timeout_q, timeout_d;

  logic        load_use;
  logic        br_taken;
  logic        rs1_hit, rs2_hit;

  // Raw (ungated) control decisions from the FSM
  logic        block_if, block_id, block_ex, inject_nops, flush_id, halted;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign rs1_hit  = id_use_rs1_i & (id_rs1_i == ex_rf_waddr_i);
  assign rs2_hit  = id_use_rs2_i & (id_rs2_i == ex_rf_waddr_i);
  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = id_valid_i & ex_valid_i & ex_memop_rd_i &
                    (ex_rf_waddr_i != 5'd0) & (rs1_hit | rs2_hit);
  assign br_taken = tkbr_i & ex_valid_i;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q   <= RUN;
      wdog_q    <= 8'd0;
      drain_q   <= 2'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      drain_q   <= drain_d;
      timeout_q <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    drain_d     = drain_q;
    timeout_d   = timeout_q;
    block_if    = 1'b0;
    block_id    = 1'b0;
    block_ex    = 1'b0;
    inject_nops = 1'b0;
    flush_id    = 1'b0;
    halted      = 1'b0;

    unique case (state_q)
      // MEM_WAIT shares the RUN priority chain: on the release cycle a branch
      // or finish held in the frozen EX flops is acted upon immediately.
      RUN, MEM_WAIT: begin
        if (mem_busy_i) begin
          block_if = 1'b1;
          block_id = 1'b1;
          block_ex = 1'b1;
          state_d  = MEM_WAIT;
          if (state_q == RUN) begin
            wdog_d = 8'd0;
          end else if (wdog_q == 8'hFF) begin
            timeout_d = 1'b1;
          end else begin
            wdog_d = 8'(wdog_q + 8'd1);
          end
        end else if (br_taken) begin
          // Branch wins over a simultaneous finish; the finishing
          // instruction comes back round after the redirect.
          inject_nops = 1'b1;
          flush_id    = 1'b1;
          state_d     = RUN;
        end else if (finish_test_i & ex_valid_i) begin
          block_if    = 1'b1;
          inject_nops = 1'b1;
          flush_id    = 1'b1;
          drain_d     = 2'd2;
          state_d     = DRAIN;
        end else if (load_use) begin
          // One bubble: load data is forwardable on the following cycle.
          block_if    = 1'b1;
          block_id    = 1'b1;
          inject_nops = 1'b1;
          state_d     = RUN;
        end else begin
          state_d     = RUN;
        end
      end

      DRAIN: begin
        block_if    = 1'b1;
        inject_nops = 1'b1;
        flush_id    = 1'b1;
        block_ex    = mem_busy_i;
        // Outstanding memory ops pause the drain count.
        if (!mem_busy_i) begin
          if (drain_q == 2'd0) begin
            state_d = HALT;
          end else begin
            drain_d = 2'(drain_q - 2'd1);
          end
        end
      end

      HALT: begin
        block_if    = 1'b1;
        inject_nops = 1'b1;
        flush_id    = 1'b1;
        block_ex    = mem_busy_i;
        halted      = 1'b1;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: forced low while reset is asserted, independent of the inputs.
  // ---------------------------------------------------------------------------
  assign block_if_o       = rsn_i & block_if;
  assign block_id_o       = rsn_i & block_id;
  assign block_ex_o       = rsn_i & block_ex;
  assign inject_nops_ex_o = rsn_i & inject_nops;
  assign flush_id_o       = rsn_i & flush_id;
  assign halted_o         = rsn_i & halted;
  assign mem_timeout_o    = rsn_i & timeout_q;
  assign state_o          = rsn_i ? state_q : 2'd0;

`ifdef SEGRE_STALL_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic        stall_evt, flush_evt;
  logic [31:0] stall_cnt_q, flush_cnt_q;

  assign stall_evt = block_if & ((state_q == RUN) | (state_q == MEM_WAIT));
  // A branch flush only happens when the RUN chain reaches the branch rule.
  assign flush_evt = ((state_q == RUN) | (state_q == MEM_WAIT)) &
                     ~mem_busy_i & br_taken;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush_evt && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_segre_pipe_ctrl.sv
// Self-checking bench for segre_pipe_ctrl.
// Per-cycle expected output vectors are queued when stimulus is applied and
// popped/compared at the following falling edge.

module tb_segre_pipe_ctrl;

  logic       clk_i = 1'b0;
  logic       rsn_i;
  logic       id_valid_i;
  logic [4:0] id_rs1_i, id_rs2_i;
  logic       id_use_rs1_i, id_use_rs2_i;
  logic       ex_valid_i, ex_memop_rd_i;
  logic [4:0] ex_rf_waddr_i;
  logic       tkbr_i, mem_busy_i, finish_test_i;
  logic       block_if_o, block_id_o, block_ex_o;
  logic       inject_nops_ex_o, flush_id_o, halted_o, mem_timeout_o;
  logic [1:0] state_o;
`ifdef SEGRE_STALL_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  string      name_q[$];

  always #5 clk_i = ~clk_i;

  segre_pipe_ctrl dut (
    .clk_i            (clk_i),
    .rsn_i            (rsn_i),
    .id_valid_i       (id_valid_i),
    .id_rs1_i         (id_rs1_i),
    .id_rs2_i         (id_rs2_i),
    .id_use_rs1_i     (id_use_rs1_i),
    .id_use_rs2_i     (id_use_rs2_i),
    .ex_valid_i       (ex_valid_i),
    .ex_memop_rd_i    (ex_memop_rd_i),
    .ex_rf_waddr_i    (ex_rf_waddr_i),
    .tkbr_i           (tkbr_i),
    .mem_busy_i       (mem_busy_i),
    .finish_test_i    (finish_test_i),
    .block_if_o       (block_if_o),
    .block_id_o       (block_id_o),
    .block_ex_o       (block_ex_o),
    .inject_nops_ex_o (inject_nops_ex_o),
    .flush_id_o       (flush_id_o),
    .halted_o         (halted_o),
    .mem_timeout_o    (mem_timeout_o),
`ifdef SEGRE_STALL_CNT_EN
    .stall_cnt_o      (stall_cnt_o),
    .flush_cnt_o      (flush_cnt_o),
`endif
    .state_o          (state_o)
  );

  // Vector: {bif, bid, bex, inj, flush, halted, timeout, state[1:0]}
  function automatic logic [8:0] ev(input logic bif, input logic bid,
                                    input logic bex, input logic inj,
                                    input logic fl, input logic hlt,
                                    input logic to, input logic [1:0] st);
    return {bif, bid, bex, inj, fl, hlt, to, st};
  endfunction

  function automatic logic [8:0] obs();
    return {block_if_o, block_id_o, block_ex_o, inject_nops_ex_o, flush_id_o,
            halted_o, mem_timeout_o, state_o};
  endfunction

  task automatic idle();
    id_valid_i    = 1'b0;
    id_rs1_i      = 5'd0;
    id_rs2_i      = 5'd0;
    id_use_rs1_i  = 1'b0;
    id_use_rs2_i  = 1'b0;
    ex_valid_i    = 1'b0;
    ex_memop_rd_i = 1'b0;
    ex_rf_waddr_i = 5'd0;
    tkbr_i        = 1'b0;
    mem_busy_i    = 1'b0;
    finish_test_i = 1'b0;
  endtask

  // Queue the expectation for the inputs currently applied, then compare
  // at the falling edge and step to just after the next rising edge.
  task automatic cyc(input string nm, input logic [8:0] e);
    logic [8:0] want;
    string      wn;
    logic [8:0] got;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk_i);
    want = exp_q.pop_front();
    wn   = name_q.pop_front();
    got  = obs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got %b want %b (bif bid bex inj fl hlt to st)",
               wn, $time, got, want);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_dut();
    idle();
    rsn_i = 1'b0;
    #3;
    @(posedge clk_i);
    #1;
    rsn_i = 1'b1;
  endtask

  task automatic test_reset();
    rsn_i = 1'b0;
    mem_busy_i    = 1'b1;
    tkbr_i        = 1'b1;
    ex_valid_i    = 1'b1;
    finish_test_i = 1'b1;
    #1;
    checks++;
    if (obs() !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want %b", obs(), 9'd0);
    end
`ifdef SEGRE_STALL_CNT_EN
    checks++;
    if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters got %0d/%0d want 0/0", stall_cnt_o, flush_cnt_o);
    end
`endif
    reset_dut();
    cyc("post_reset_idle", ev(0,0,0,0,0,0,0,2'd0));
  endtask

  task automatic test_load_use();
    // EX load to x5, ID reads rs2 = x5
    id_valid_i = 1'b1; id_use_rs2_i = 1'b1; id_rs2_i = 5'd5;
    ex_valid_i = 1'b1; ex_memop_rd_i = 1'b1; ex_rf_waddr_i = 5'd5;
    cyc("load_use_rs2", ev(1,1,0,1,0,0,0,2'd0));
    // Next cycle EX holds the bubble: no further stall
    ex_valid_i = 1'b0; ex_memop_rd_i = 1'b0;
    cyc("load_use_one_bubble", ev(0,0,0,0,0,0,0,2'd0));
    // rs1 path
    id_use_rs2_i = 1'b0; id_use_rs1_i = 1'b1; id_rs1_i = 5'd7;
    ex_valid_i = 1'b1; ex_memop_rd_i = 1'b1; ex_rf_waddr_i = 5'd7;
    cyc("load_use_rs1", ev(1,1,0,1,0,0,0,2'd0));
    // Same register but operand not used
    id_use_rs1_i = 1'b0;
    cyc("load_use_not_read", ev(0,0,0,0,0,0,0,2'd0));
    // x0 never stalls
    id_use_rs2_i = 1'b1; id_rs2_i = 5'd0; ex_rf_waddr_i = 5'd0;
    cyc("load_use_x0", ev(0,0,0,0,0,0,0,2'd0));
    // Non-load producer does not stall
    id_rs2_i = 5'd5; ex_rf_waddr_i = 5'd5; ex_memop_rd_i = 1'b0;
    cyc("load_use_not_load", ev(0,0,0,0,0,0,0,2'd0));
    idle();
  endtask

  task automatic test_branch();
    tkbr_i = 1'b1; ex_valid_i = 1'b1;
    cyc("branch_taken", ev(0,0,0,1,1,0,0,2'd0));
    tkbr_i = 1'b0;
    cyc("branch_one_cycle", ev(0,0,0,0,0,0,0,2'd0));
    tkbr_i = 1'b1; ex_valid_i = 1'b0;
    cyc("branch_ex_invalid", ev(0,0,0,0,0,0,0,2'd0));
    // Branch + finish together resolve as branch only
    tkbr_i = 1'b1; ex_valid_i = 1'b1; finish_test_i = 1'b1;
    cyc("branch_and_finish", ev(0,0,0,1,1,0,0,2'd0));
    idle();
    cyc("branch_and_finish_stays_run", ev(0,0,0,0,0,0,0,2'd0));
    // Branch beats a simultaneous load-use
    tkbr_i = 1'b1; ex_valid_i = 1'b1; ex_memop_rd_i = 1'b1; ex_rf_waddr_i = 5'd3;
    id_valid_i = 1'b1; id_use_rs1_i = 1'b1; id_rs1_i = 5'd3;
    cyc("branch_over_load_use", ev(0,0,0,1,1,0,0,2'd0));
    idle();
  endtask

  task automatic test_mem_stall();
    tkbr_i = 1'b1; ex_valid_i = 1'b1; mem_busy_i = 1'b1;
    cyc("mem_stall_c1", ev(1,1,1,0,0,0,0,2'd0));
    cyc("mem_stall_c2", ev(1,1,1,0,0,0,0,2'd1));
    cyc("mem_stall_c3", ev(1,1,1,0,0,0,0,2'd1));
    mem_busy_i = 1'b0;
    cyc("mem_stall_release_flush", ev(0,0,0,1,1,0,0,2'd1));
    idle();
    cyc("mem_stall_back_to_run", ev(0,0,0,0,0,0,0,2'd0));
  endtask

  task automatic test_watchdog();
    mem_busy_i = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      if (i == 1)
        cyc("wdog_enter", ev(1,1,1,0,0,0,0,2'd0));
      else
        cyc("wdog_busy", ev(1,1,1,0,0,0,(i >= 258),2'd1));
    end
    mem_busy_i = 1'b0;
    cyc("wdog_release", ev(0,0,0,0,0,0,1,2'd1));
    cyc("wdog_sticky", ev(0,0,0,0,0,0,1,2'd0));
  endtask

  task automatic test_async_reset();
    mem_busy_i = 1'b1;
    cyc("ar_enter", ev(1,1,1,0,0,0,1,2'd0));
    cyc("ar_wait", ev(1,1,1,0,0,0,1,2'd1));
    #2;
    rsn_i = 1'b0;
    #1;
    checks++;
    if (obs() !== 9'd0) begin
      errors++;
      $display("FAIL async_reset_mem_wait got %b want %b", obs(), 9'd0);
    end
    reset_dut();
    cyc("ar_cleared", ev(0,0,0,0,0,0,0,2'd0));
  endtask

  task automatic test_finish();
    ex_valid_i = 1'b1; finish_test_i = 1'b1;
    cyc("fin_enter", ev(1,0,0,1,1,0,0,2'd0));
    idle();
    cyc("fin_drain1", ev(1,0,0,1,1,0,0,2'd2));
    cyc("fin_drain2", ev(1,0,0,1,1,0,0,2'd2));
    cyc("fin_drain3", ev(1,0,0,1,1,0,0,2'd2));
    cyc("fin_halt", ev(1,0,0,1,1,1,0,2'd3));
    // HALT ignores further activity
    tkbr_i = 1'b1; ex_valid_i = 1'b1;
    cyc("fin_halt_sticky", ev(1,0,0,1,1,1,0,2'd3));
    idle();
    reset_dut();
  endtask

  task automatic test_finish_busy();
    ex_valid_i = 1'b1; finish_test_i = 1'b1;
    cyc("finb_enter", ev(1,0,0,1,1,0,0,2'd0));
    idle();
    cyc("finb_drain1", ev(1,0,0,1,1,0,0,2'd2));
    mem_busy_i = 1'b1;
    cyc("finb_busy1", ev(1,0,1,1,1,0,0,2'd2));
    cyc("finb_busy2", ev(1,0,1,1,1,0,0,2'd2));
    mem_busy_i = 1'b0;
    cyc("finb_drain2", ev(1,0,0,1,1,0,0,2'd2));
    cyc("finb_drain3", ev(1,0,0,1,1,0,0,2'd2));
    cyc("finb_halt", ev(1,0,0,1,1,1,0,2'd3));
    reset_dut();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rsn_i = 1'b0;
    @(posedge clk_i);
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_stall();
    test_watchdog();
    test_async_reset();
    test_finish();
    test_finish_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/segre_pipe_ctrl.md
SEGRE_PIPE_CTRL -- requirements
Module: segre_pipe_ctrl

Interface
- REQ-001 SHALL provide ports:
  - clk_i  in  1  clock; all state changes on its rising edge.
  - rsn_i  in  1  reset; asynchronous, active-low.
  - id_valid_i  in  1  ID holds a valid instruction.
  - id_rs1_i / id_rs2_i  in  5 each  ID source registers.
  - id_use_rs1_i / id_use_rs2_i  in  1 each  ID instruction reads rs1/rs2.
  - ex_valid_i  in  1  EX flops hold a valid instruction (EX valid_ex_o).
  - ex_memop_rd_i  in  1  EX instruction is a load.
  - ex_rf_waddr_i  in  5  EX destination register.
  - tkbr_i  in  1  EX branch/jump taken.
  - mem_busy_i  in  1  MEM stage cannot accept/complete this cycle.
  - finish_test_i  in  1  EX instruction ends the test.
  - block_if_o / block_id_o / block_ex_o  out  1 each  hold the stage flops.
  - inject_nops_ex_o  out  1  EX loads a bubble (drives EX inject_nops_i).
  - flush_id_o  out  1  invalidate the IF/ID register.
  - halted_o  out  1  core halted.
  - mem_timeout_o  out  1  sticky watchdog error.
  - state_o  out  2  FSM state; RUN=0, MEM_WAIT=1, DRAIN=2, HALT=3.
- REQ-002 SHALL drive all outputs combinationally from the registered state and the same-cycle inputs (Mealy); no input-to-output path SHALL pass through a flop.

Function
- REQ-003 load_use SHALL equal id_valid_i & ex_valid_i & ex_memop_rd_i & (ex_rf_waddr_i != 0) & ((id_use_rs1_i & id_rs1_i == ex_rf_waddr_i) | (id_use_rs2_i & id_rs2_i == ex_rf_waddr_i)).
- REQ-004 br_taken SHALL equal tkbr_i & ex_valid_i.
- REQ-005 In RUN, the first matching rule SHALL apply (priority order):
  - mem_busy_i: block_if, block_id and block_ex = 1; next state MEM_WAIT; watchdog cleared to 0.
  - br_taken: inject_nops_ex = 1, flush_id = 1; stay in RUN.
  - finish_test_i & ex_valid_i: block_if = 1, inject_nops_ex = 1, flush_id = 1; drain counter = 2; next state DRAIN.
  - load_use: block_if = 1, block_id = 1, inject_nops_ex = 1; stay in RUN (exactly one bubble).
  - Otherwise all control outputs = 0.
- REQ-006 MEM_WAIT SHALL work as follows:
  - While mem_busy_i = 1: block_if, block_id and block_ex = 1; the 8-bit watchdog increments.
  - At count 255 with mem_busy_i still 1, mem_timeout_o SHALL set and stay set until reset; the count saturates at 255.
- REQ-007 In MEM_WAIT with mem_busy_i = 0, the RUN rules of REQ-005 SHALL apply in that same cycle (next state from those rules, MEM_WAIT replaced by RUN where mem_busy_i is low). This lets a branch held in blocked EX flush on the release cycle.
- REQ-008 DRAIN SHALL work as follows:
  - block_if = 1, inject_nops_ex = 1, flush_id = 1 every cycle.
  - The counter decrements only when mem_busy_i = 0.
  - When the counter is 0 with mem_busy_i = 0, next state HALT.
  - mem_busy_i = 1 in DRAIN SHALL also assert block_ex.
- REQ-009 HALT SHALL drive the DRAIN outputs plus halted_o = 1 and SHALL exit only on reset.
- REQ-010 tkbr_i and finish_test_i arriving in the same RUN cycle SHALL resolve as br_taken only. The finishing instruction is then re-seen when it next reaches EX.
- REQ-011 Register 0 SHALL never cause load_use.

Reset
- REQ-012 On rsn_i low, the following SHALL clear immediately (asynchronously), including mid-operation:
  - state = RUN
  - watchdog = 0
  - drain counter = 0
  - mem_timeout_o = 0
  - halted_o = 0
- REQ-013 During reset, every control output SHALL be 0, state_o SHALL be 0, and the (SEGRE_STALL_CNT_EN) counters SHALL be 0.

Configuration
- REQ-014 With SEGRE_STALL_CNT_EN defined, SHALL add two outputs:
  - stall_cnt_o (32): cycles with block_if_o = 1 in RUN or MEM_WAIT.
  - flush_cnt_o (32): br_taken flush events.
  - Both saturate at all-ones.
- REQ-015 Without SEGRE_STALL_CNT_EN, those ports and counters SHALL be absent and all other behaviour SHALL be unchanged.

Verification
- REQ-016 Load-use: EX load to x5, ID reads rs2 = x5 -> block_if = block_id = inject_nops_ex = 1 for exactly 1 cycle; same with waddr = 0 -> no stall.
- REQ-017 Branch: tkbr_i = 1, ex_valid_i = 1 -> inject_nops_ex = flush_id = 1 for 1 cycle; with ex_valid_i = 0 -> no flush.
- REQ-018 Memory stall, watchdog below limit: mem_busy_i high for 3 cycles while tkbr_i = 1 -> all blocks high for 3 cycles, state_o = 1; the flush is asserted on the release cycle; state_o = 0 afterward.
- REQ-019 Memory stall, watchdog limit: mem_busy_i high for 300 cycles -> mem_timeout_o rises after cycle 256 and stays high after release.
- REQ-020 Finish: finish_test_i with ex_valid_i -> DRAIN; halted_o high 3 cycles later; a 2-cycle mem_busy_i inside DRAIN delays halt by 2 cycles.
- REQ-021 Reset in MEM_WAIT with mem_timeout_o set -> all outputs 0 and state_o = 0 without a clock edge.
